hamming_decoder: RTL and testbench

Sequential SECDED decoder for the 16-bit Hamming codewords that the processor's parity-based encode program produces using the ALU reduction-XOR flag. It accepts a codeword as two bytes over a valid/ready byte interface and scans it one bit per cycle to build the syndrome and overall parity. It then corrects any single-bit error and returns the 11 data bits with a status code. It sits beside data memory as the hardware check for the decode program, and as a standalone decode accelerator.

---
 rtl/hamming_decoder.sv | 122 ++++++++++++
 tb/tb_hamming_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// hamming_decoder: sequential SECDED decoder for 16-bit Hamming codewords.
// A codeword arrives as two bytes, LSB first. The decoder then scans it one bit per
// cycle to build the syndrome and overall parity. It corrects a single-bit error,
// flags a double error, and presents the 11 data bits until the consumer takes them.
module hamming_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_data,
    output logic [1:0]  out_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        GET_LO,
        GET_HI,
        SCAN,
        FIX,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cw_q, cw_d;
    logic [3:0]  syn_q, syn_d;
    logic        par_q, par_d;
    logic [3:0]  idx_q, idx_d;
    logic [10:0] outData_q, outData_d;
    logic [1:0]  outErr_q, outErr_d;
    logic [15:0] fixedCw;

    // State and datapath registers; reset may strike in any state, including mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GET_LO;
            cw_q      <= '0;
            syn_q     <= '0;
            par_q     <= 1'b0;
            idx_q     <= '0;
            outData_q <= '0;
            outErr_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cw_q      <= cw_d;
            syn_q     <= syn_d;
            par_q     <= par_d;
            idx_q     <= idx_d;
            outData_q <= outData_d;
            outErr_q  <= outErr_d;
        end
    end

    // Next-state logic: byte capture, bit-serial syndrome scan, correction decision, handoff.
    always_comb begin
        state_d   = state_q;
        cw_d      = cw_q;
        syn_d     = syn_q;
        par_d     = par_q;
        idx_d     = idx_q;
        outData_d = outData_q;
        outErr_d  = outErr_q;
        fixedCw   = cw_q;

        case (state_q)
            GET_LO: begin
                if (in_valid) begin
                    cw_d[7:0] = in_byte;
                    state_d   = GET_HI;
                end
            end
            GET_HI: begin
                if (in_valid) begin
                    cw_d[15:8] = in_byte;
                    syn_d      = 4'd0;
                    par_d      = 1'b0;
                    idx_d      = 4'd0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                par_d = par_q ^ cw_q[idx_q];
                if (cw_q[idx_q]) begin
                    syn_d = syn_q ^ idx_q;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (par_q) begin
                    fixedCw[syn_q] = ~cw_q[syn_q];
                    outErr_d       = 2'b01;
                end else if (syn_q != 4'd0) begin
                    outErr_d = 2'b10;
                end else begin
                    outErr_d = 2'b00;
                end
                outData_d = {fixedCw[15:9], fixedCw[7:5], fixedCw[3]};
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = GET_LO;
                end
            end
            default: begin
                state_d = GET_LO;
            end
        endcase
    end

    assign in_ready  = (state_q == GET_LO) || (state_q == GET_HI);
    assign busy      = (state_q != GET_LO);
    assign out_valid = (state_q == DONE);
    assign out_data  = outData_q;
    assign out_err   = outErr_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: table-driven directed vectors plus backpressure and mid-scan reset sequences.
`timescale 1ns/1ps
module tb_hamming_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [1:0]  out_err;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [10:0] expData;
        logic [1:0]  expErr;
    } vector_t;

    vector_t vectors[9];

    hamming_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Sends both bytes back-to-back, then waits for out_valid and checks its latency from the MSB edge.
    task automatic applyStimulus(input logic [7:0] lo, input logic [7:0] hi, input string name);
        int cycles;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = lo;
        @(posedge clk);
        @(negedge clk);
        in_byte = hi;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'h00;
        checkOutput({name, " busy in scan"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput({name, " latency"}, 32'(cycles), 32'd17);
    endtask

    // Accepts the pending result and checks the handoff behaviour on the following cycle.
    task automatic consumeResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vectors[0] = '{lo: 8'h0F, hi: 8'h00, expData: 11'h001, expErr: 2'b00};
        vectors[1] = '{lo: 8'h07, hi: 8'h00, expData: 11'h001, expErr: 2'b01};
        vectors[2] = '{lo: 8'h0E, hi: 8'h00, expData: 11'h001, expErr: 2'b01};
        vectors[3] = '{lo: 8'h07, hi: 8'h04, expData: 11'h020, expErr: 2'b10};
        vectors[4] = '{lo: 8'hFF, hi: 8'hFF, expData: 11'h7FF, expErr: 2'b00};
        vectors[5] = '{lo: 8'hFF, hi: 8'h7F, expData: 11'h7FF, expErr: 2'b01};
        vectors[6] = '{lo: 8'hFC, hi: 8'hFF, expData: 11'h7FF, expErr: 2'b10};
        vectors[7] = '{lo: 8'h00, hi: 8'h00, expData: 11'h000, expErr: 2'b00};
        vectors[8] = '{lo: 8'h00, hi: 8'h01, expData: 11'h000, expErr: 2'b01};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        #23;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'h000);
        checkOutput("reset out_err", 32'(out_err), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].lo, vectors[i].hi, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vectors[i].expData));
            checkOutput($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vectors[i].expErr));
            consumeResult($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while junk bytes are offered and refused.
        applyStimulus(8'h07, 8'h00, "bp");
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_byte = 8'(8'hA5 + c);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp out_data c%0d", c), 32'(out_data), 32'h001);
            checkOutput($sformatf("bp out_err c%0d", c), 32'(out_err), 32'd1);
            checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consumeResult("bp");
        checkOutput("bp out_data retained", 32'(out_data), 32'h001);
        checkOutput("bp out_err retained", 32'(out_err), 32'd1);
        applyStimulus(8'hFF, 8'hFF, "post bp");
        checkOutput("post bp out_data", 32'(out_data), 32'h7FF);
        checkOutput("post bp out_err", 32'(out_err), 32'd0);
        consumeResult("post bp");

        // Reset mid-scan: after seven scan edges idx has reached 7.
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        in_byte = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset out_data", 32'(out_data), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h0F, 8'h00, "after reset");
        checkOutput("after reset out_data", 32'(out_data), 32'h001);
        checkOutput("after reset out_err", 32'(out_err), 32'd0);
        consumeResult("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
